// File: rtl/alu_seq.sv
// alu_seq: issues one accumulator load or one external 8-bit ALU op per accepted instruction.
// Latency: a load raises done on the cycle after accept; an ALU op captures and raises done ALU_LAT edges after accept.
// Backpressure: in_ready is low while an ALU op settles, and the source holds in_valid. Optional macro: ALU_SEQ_CARRY_CHAIN_EN.
module alu_seq #(
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [7:0] in_operand,
  input  logic       in_load,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_s,
  output logic       alu_cin,
  input  logic [7:0] alu_d,
  input  logic       alu_cout,
  output logic [7:0] acc,
  output logic       flag_c,
  output logic       flag_z,
  output logic       done
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] hold_op;
  logic [7:0] hold_b;
  logic [7:0] a_q;
  logic       accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Operand registers are loaded only at accept, so the ALU sees a frozen
  // instruction for the whole settle window regardless of the input bus.
  assign alu_a = a_q;
  assign alu_b = hold_b;
  assign alu_s = hold_op;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic cin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cin_q <= 1'b0;
    end else if (accept && !in_load) begin
      cin_q <= flag_c;
    end
  end

  assign alu_cin = cin_q;
`else
  assign alu_cin = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      hold_op <= 4'd0;
      hold_b  <= 8'h00;
      a_q     <= 8'h00;
      acc     <= 8'h00;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_load) begin
              acc    <= in_operand;
              flag_z <= (in_operand == 8'h00);
              done   <= 1'b1;
            end else begin
              hold_op <= in_op;
              hold_b  <= in_operand;
              a_q     <= acc;
              cnt     <= CNT_INIT;
              state   <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            acc    <= alu_d;
            flag_z <= (alu_d == 8'h00);
            // Carry is architectural only for the arithmetic group.
            if (hold_op[3:2] == 2'b00) begin
              flag_c <= alu_cout;
            end
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioural ALU drives alu_d/alu_cout, and an accumulator-level model predicts acc, flags and done timing.
module tb_alu_seq;
  localparam int LAT = 2;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = 4'd0;
  logic [7:0] in_operand = 8'h00;
  logic       in_load = 1'b0;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_s;
  logic       alu_cin;
  logic [7:0] alu_d;
  logic       alu_cout;
  logic [7:0] acc;
  logic       flag_c, flag_z, done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_acc = 8'h00;
  logic       m_c   = 1'b0;
  logic       m_z   = 1'b0;

  alu_seq #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_operand(in_operand), .in_load(in_load),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_d(alu_d), .alu_cout(alu_cout),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .done(done)
  );

  always #5 clk = ~clk;

  // Bench ALU: returns {cout, d}. Non-arithmetic ops still produce a carry
  // so that wrongly captured carries become visible.
  function automatic logic [8:0] alu_f(input logic [3:0] s, input logic [7:0] a,
                                       input logic [7:0] b, input logic ci);
    logic [8:0] r;
    case (s)
      4'h0: r = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      4'h1: r = {1'b0, a} - {1'b0, b};
      4'h2: r = {1'b0, a} + 9'd1;
      4'h3: r = {1'b0, a} + {1'b0, b};
      4'h4: begin r[7:0] = a & b; r[8] = ^r[7:0]; end
      4'h5: begin r[7:0] = a | b; r[8] = ^r[7:0]; end
      4'h6: begin r[7:0] = a ^ b; r[8] = ^r[7:0]; end
      4'h7: begin r[7:0] = ~a;    r[8] = ^r[7:0]; end
      4'h8: r = {a[0], 1'b0, a[7:1]};
      4'h9: r = {a[0], a[0], a[7:1]};
      4'hC: r = {a[7], a[6:0], 1'b0};
      default: r = {~b[0], b};
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_d} = alu_f(alu_s, alu_a, alu_b, alu_cin);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction while the DUT is idle. lat counts edges after the
  // accept edge until done is seen high. b2b leaves the bench in the done
  // cycle so the next call is accepted there.
  task automatic run(input logic ld, input logic [3:0] op, input logic [7:0] opd, input bit b2b);
    logic [7:0] a0;
    logic       ci;
    logic [8:0] r;
    int         lat;
    int         want;
    a0 = m_acc;
    ci = CHAIN ? m_c : 1'b0;
    if (ld) begin
      m_acc = opd;
      m_z   = (opd == 8'h00);
      want  = 0;
    end else begin
      r     = alu_f(op, a0, opd, ci);
      m_acc = r[7:0];
      m_z   = (r[7:0] == 8'h00);
      if (op[3:2] == 2'b00) m_c = r[8];
      want  = LAT;
    end
    in_valid = 1'b1; in_load = ld; in_op = op; in_operand = opd;
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    lat = 0;
    in_valid = !ld;
    in_op = 4'($urandom); in_operand = 8'($urandom); in_load = 1'($urandom);
    while (!done && lat < 20) begin
      chk("ready_in_settle", 32'(in_ready), 32'd0);
      chk("alu_a", 32'(alu_a), 32'(a0));
      chk("alu_b", 32'(alu_b), 32'(opd));
      chk("alu_s", 32'(alu_s), 32'(op));
      chk("alu_cin", 32'(alu_cin), 32'(ci));
      @(posedge clk); #1;
      lat++;
      in_op = 4'($urandom); in_operand = 8'($urandom);
    end
    chk(ld ? "load_latency" : "alu_latency", 32'(lat), 32'(want));
    chk("acc", 32'(acc), 32'(m_acc));
    chk("flag_c", 32'(flag_c), 32'(m_c));
    chk("flag_z", 32'(flag_z), 32'(m_z));
    chk("ready_in_done_cycle", 32'(in_ready), 32'd1);
    if (!b2b) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("acc_hold", 32'(acc), 32'(m_acc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", 32'(acc), 32'h00);
    chk("rst_flag_c", 32'(flag_c), 32'd0);
    chk("rst_flag_z", 32'(flag_z), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_b", 32'(alu_b), 32'h00);
    chk("rst_alu_s", 32'(alu_s), 32'h0);
    chk("rst_alu_cin", 32'(alu_cin), 32'd0);
    rst_n = 1'b1;

    run(1'b1, 4'h0, 8'h81, 1'b0);
    run(1'b0, 4'h8, 8'h00, 1'b0);
    run(1'b0, 4'hC, 8'h3C, 1'b1);
    run(1'b0, 4'hC, 8'h00, 1'b0);
    chk("shift_to_zero_acc", 32'(acc), 32'h00);
    chk("shift_to_zero_z", 32'(flag_z), 32'd1);

    run(1'b1, 4'h0, 8'hF0, 1'b0);
    run(1'b0, 4'h0, 8'h20, 1'b1);
    chk("add_carry_out", 32'(flag_c), 32'd1);
    run(1'b0, 4'h8, 8'h00, 1'b0);
    chk("shift_keeps_carry", 32'(flag_c), 32'd1);

    for (int i = 0; i < 60; i++) begin
      run(1'($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom), 1'($urandom));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    in_valid = 1'b1; in_load = 1'b0; in_op = 4'h0; in_operand = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0;
    #1;
    chk("midrst_async_acc", 32'(acc), 32'h00);
    chk("midrst_async_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    chk("midrst_acc", 32'(acc), 32'h00);
    chk("midrst_flag_c", 32'(flag_c), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    run(1'b0, 4'h3, 8'h11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter ALU_LAT, default 2, the number of ALU settle cycles between operand launch and result capture (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  instruction offered.
REQ-005 SHALL have port in_ready  output  1  instruction accepted when in_valid&&in_ready at a rising edge.
REQ-006 SHALL have port in_op  input  4  ALU select code, passed to alu_s.
REQ-007 SHALL have port in_operand  input  8  B operand, or load value.
REQ-008 SHALL have port in_load  input  1  load in_operand into the accumulator, ALU bypassed.
REQ-009 SHALL have ports alu_a  output  8, alu_b  output  8, alu_s  output  4, alu_cin  output  1  drive the 8-bit ALU.
REQ-010 SHALL have ports alu_d  input  8, alu_cout  input  1  ALU result and carry-out.
REQ-011 SHALL have ports acc  output  8, flag_c  output  1, flag_z  output  1  architectural state.
REQ-012 SHALL have port done  output  1  one-cycle pulse, asserted when acc/flags hold the new result.

Function
REQ-013 SHALL implement FSM states IDLE and SETTLE; in_ready = (state==IDLE).
REQ-014 IDLE, accept with in_load=1: acc<=in_operand; flag_z<=(in_operand==0); flag_c unchanged; stay IDLE; done=1 next cycle.
REQ-015 IDLE, accept with in_load=0: latch in_op/in_operand into hold registers; counter<=ALU_LAT-1; go SETTLE.
REQ-016 alu_a=acc, alu_b=held operand, alu_s=held op, all registered, stable from the accept edge until capture.
REQ-017 SETTLE: counter decrements each edge; on the edge where counter==0: acc<=alu_d, flag_z<=(alu_d==0), state<=IDLE, done<=1.
REQ-018 Same capture edge: flag_c<=alu_cout only if held op[3:2]==2'b00 (arithmetic group); otherwise flag_c unchanged.
REQ-019 Latency: ALU op accepted at edge E0 -> capture and done at edge E0+ALU_LAT; load -> done at edge E0+1.
REQ-020 done SHALL be high for exactly one cycle per accepted instruction, otherwise 0.
REQ-021 Back-to-back: a new instruction SHALL be acceptable in the same cycle done is high; no bubble is required.
REQ-022 in_valid during SETTLE SHALL be ignored (not accepted, not lost by the block; the source holds it).
REQ-023 in_op/in_operand changes during SETTLE SHALL NOT affect alu_* outputs.

Reset
REQ-024 While rst_n=0: state=IDLE, acc=8'h00, flag_c=0, flag_z=0, done=0, counter=0, hold registers=0, in_ready=1.
REQ-025 Reset asserted mid-SETTLE SHALL abort the operation; no capture and no done after release.
REQ-026 First acceptance is possible on the first rising edge with rst_n=1.

Configuration
REQ-027 Macro ALU_SEQ_CARRY_CHAIN_EN defined: alu_cin=flag_c, registered at the accept edge, for multi-byte chaining.
REQ-028 Macro ALU_SEQ_CARRY_CHAIN_EN undefined: alu_cin is constant 0; flag_c is still updated per REQ-018.

Verification
REQ-029 Reset pulse -> acc=00, flag_c=0, flag_z=0, done=0, in_ready=1.
REQ-030 Load 0x81 -> acc=0x81, flag_z=0, done one cycle later, in_ready never drops.
REQ-031 ALU_LAT=2, acc=0x81, op 4'b1000 with the bench ALU returning {0,A[7:1]} -> alu_a=0x81, done 2 edges after accept, acc=0x40; then 4'b1100 (left shift) twice -> 0x80, then 0x00 with flag_z=1.
REQ-032 Op 4'b0000, bench returns alu_cout=1 -> flag_c=1; next op 4'b1000 leaves flag_c=1; with ALU_SEQ_CARRY_CHAIN_EN, alu_cin=1 during that op, without it alu_cin=0.
REQ-033 in_valid held high through SETTLE -> in_ready=0, single accept, second instruction accepted in the done cycle.
REQ-034 rst_n low for one cycle mid-SETTLE -> acc=00, no done pulse, in_ready=1 after release.
